// File: rtl/alu_sched_pkg.sv
// Shared definitions for the two-requester ALU scheduler: op codes, FSM states
// and the default MOD unit latency.
package alu_sched_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_LT  = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  localparam int MOD_LAT_DEF = 34;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    EXEC = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the pointer names the side that wins a tie and
// moves to the other side after every grant taken while advance is high.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr
);

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Scheduler in front of the shared ALU: arbitrates two requesters, registers
// operands onto the ALU, sequences the multi-cycle MOD and returns the result.
//   state | meaning
//   IDLE  | readies live, waiting for a request
//   CLR   | MOD only, alu_clr pulsed for one cycle
//   EXEC  | down-counter running, ALU inputs held
//   RESP  | response held until rsp_ready
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MOD_LAT = MOD_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  output logic             alu_clr,
  input  logic [WIDTH-1:0] alu_res,
  output logic             busy
);

  localparam int CW = $clog2(MOD_LAT + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             id_q;
  logic             err_q;
  logic [1:0]       grant;
  logic             ptr_unused;
  logic             accept_ok;
  logic             accept;
  logic [2:0]       acc_op;
  logic [WIDTH-1:0] acc_a;
  logic [WIDTH-1:0] acc_b;
  logic             acc_mod;

  // Readies are gated by reset so a held valid cannot look accepted in reset.
  assign accept_ok  = (state == IDLE) && reset;
  assign req0_ready = accept_ok & grant[0];
  assign req1_ready = accept_ok & grant[1];
  assign accept     = req0_ready | req1_ready;

  assign acc_op  = grant[1] ? req1_op : req0_op;
  assign acc_a   = grant[1] ? req1_a  : req0_a;
  assign acc_b   = grant[1] ? req1_b  : req0_b;
  assign acc_mod = (acc_op == OP_MOD);

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1_valid, req0_valid}),
    .advance (accept_ok),
    .grant   (grant),
    .ptr     (ptr_unused)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      id_q     <= 1'b0;
      err_q    <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= OP_AND;
      alu_clr  <= 1'b0;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      alu_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a   <= acc_a;
            alu_b   <= acc_b;
            alu_sel <= acc_op;
            id_q    <= grant[1];
            err_q   <= acc_mod && (acc_b == '0);
            cnt     <= CW'(1);
            if (acc_mod && (acc_b != '0)) begin
              alu_clr <= 1'b1;
              state   <= CLR;
            end else begin
              state <= EXEC;
            end
          end
        end
        CLR: begin
          cnt   <= CW'(MOD_LAT);
          state <= EXEC;
        end
        EXEC: begin
          if (cnt == CW'(1)) begin
            // Divide-by-zero bypasses the ALU and returns the dividend.
            rsp_data <= err_q ? alu_a : alu_res;
            rsp_err  <= err_q;
            rsp_id   <= id_q;
            state    <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched with a behavioural ALU stand-in and a
// job-level reference model (result, latency, grant order).
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int WIDTH   = 32;
  localparam int MOD_LAT = 34;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [2:0]       req0_op = '0, req1_op = '0;
  logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic             rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_err;
  logic [WIDTH-1:0] rsp_data, alu_a, alu_b, alu_res;
  logic [2:0]       alu_sel;
  logic             alu_clr, busy;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  exp_ptr = 1'b0;
  time last_accept = 0;
  int unsigned mod_age = 0;

  always #5 clk = ~clk;

  alu_sched #(.WIDTH(WIDTH), .MOD_LAT(MOD_LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_clr(alu_clr),
    .alu_res(alu_res), .busy(busy)
  );

  // ALU stand-in: MOD result only becomes valid MOD_LAT cycles after a clear.
  always @(posedge clk) begin
    if (alu_clr) mod_age <= 1;
    else if (mod_age != 0 && mod_age < 1000) mod_age <= mod_age + 1;
  end

  always_comb begin
    case (alu_sel)
      3'b000:  alu_res = alu_a & alu_b;
      3'b001:  alu_res = alu_a | alu_b;
      3'b010:  alu_res = alu_a ^ alu_b;
      3'b011:  alu_res = ~(alu_a | alu_b);
      3'b100:  alu_res = alu_a + alu_b;
      3'b101:  alu_res = (alu_a < alu_b) ? 32'd1 : 32'd0;
      3'b110:  alu_res = alu_a - alu_b;
      default: alu_res = (mod_age >= MOD_LAT && alu_b != 0) ? alu_a % alu_b : 32'hDEAD_BEEF;
    endcase
  end

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a | b);
      3'd4:    return a + b;
      3'd5:    return (a < b) ? 32'd1 : 32'd0;
      3'd6:    return a - b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic do_job(input bit v0, input bit v1,
                        input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                        input string tag);
    bit          g, exp_err, exp_clr, clr_bad;
    logic [2:0]  op;
    logic [31:0] a, b, exp_d;
    int          exp_lat, cyc;
    @(negedge clk);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    #1;
    g = (v0 && v1) ? exp_ptr : v1;
    n_tests++;
    if (req0_ready !== !g || req1_ready !== g) begin
      n_fail++;
      $display("FAIL %s grant: ready0=%b ready1=%b, expected ready0=%b ready1=%b", tag, req0_ready, req1_ready, !g, g);
    end
    @(posedge clk);
    last_accept = $time;
    exp_ptr = !g;
    op = g ? op1 : op0;
    a  = g ? a1 : a0;
    b  = g ? b1 : b0;
    exp_d   = ref_result(op, a, b);
    exp_err = (op == OP_MOD) && (b == 0);
    exp_clr = (op == OP_MOD) && (b != 0);
    exp_lat = exp_clr ? MOD_LAT + 2 : 2;
    clr_bad = 1'b0;
    @(negedge clk);
    cyc = 1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n_tests++;
    if (alu_sel !== op || alu_a !== a || alu_b !== b || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s alu_in: sel=%b a=%h b=%h busy=%b, expected sel=%b a=%h b=%h busy=1", tag, alu_sel, alu_a, alu_b, busy, op, a, b);
    end
    while (rsp_valid !== 1'b1 && cyc < MOD_LAT + 20) begin
      if (alu_clr !== (exp_clr && cyc == 1)) clr_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (rsp_valid !== 1'b1 || cyc != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: rsp_valid=%b at cycle %0d, expected 1 at cycle %0d", tag, rsp_valid, cyc, exp_lat);
    end
    n_tests++;
    if (rsp_data !== exp_d || rsp_id !== g || rsp_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s rsp: data=%h id=%b err=%b, expected data=%h id=%b err=%b", tag, rsp_data, rsp_id, rsp_err, exp_d, g, exp_err);
    end
    n_tests++;
    if (clr_bad) begin
      n_fail++;
      $display("FAIL %s alu_clr: pulse pattern wrong, expected %0d pulse(s) in cycle 1", tag, exp_clr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: ready0=%b ready1=%b, expected 0 0", req0_ready, req1_ready);
    end
    n_tests++;
    if ({rsp_valid, rsp_id, rsp_err, alu_clr, busy} !== 5'b0 || rsp_data !== 0 || alu_a !== 0 || alu_b !== 0 || alu_sel !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b id=%b err=%b clr=%b busy=%b data=%h a=%h b=%h sel=%b, expected all 0",
               rsp_valid, rsp_id, rsp_err, alu_clr, busy, rsp_data, alu_a, alu_b, alu_sel);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1; rsp_ready = 1'b1; exp_ptr = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b rsp_valid=%b, expected 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_contention();
    do_job(1, 1, OP_XOR, 32'hF0F0, 32'h0FF0, OP_SUB, 32'd10, 32'd3, "contend_first");
    do_job(0, 1, OP_XOR, 32'hF0F0, 32'h0FF0, OP_SUB, 32'd10, 32'd3, "contend_second");
  endtask

  task automatic test_add();
    do_job(1, 0, OP_ADD, 32'd5, 32'd7, OP_AND, 32'd0, 32'd0, "add");
  endtask

  task automatic test_contention_ptr1();
    do_job(1, 1, OP_XOR, 32'hF0F0, 32'h0FF0, OP_SUB, 32'd10, 32'd3, "contend_ptr1");
  endtask

  task automatic test_mod();
    do_job(1, 0, OP_MOD, 32'd100, 32'd7, OP_AND, 32'd0, 32'd0, "mod");
    do_job(0, 1, OP_AND, 32'd0, 32'd0, OP_MOD, 32'h1234, 32'd0, "mod_zero");
  endtask

  task automatic test_back_to_back();
    time t0;
    do_job(1, 0, OP_ADD, 32'd1, 32'd2, OP_AND, 32'd0, 32'd0, "b2b_a");
    t0 = last_accept;
    do_job(0, 1, OP_AND, 32'd0, 32'd0, OP_OR, 32'h10, 32'h01, "b2b_b");
    n_tests++;
    if (last_accept - t0 != 30) begin
      n_fail++;
      $display("FAIL b2b_spacing: %0t between accepts, expected 30", last_accept - t0);
    end
    do_job(1, 0, OP_MOD, 32'd1000, 32'd13, OP_AND, 32'd0, 32'd0, "b2b_mod");
    t0 = last_accept;
    do_job(1, 0, OP_NOR, 32'h0F, 32'hF0, OP_AND, 32'd0, 32'd0, "b2b_after_mod");
    n_tests++;
    if (last_accept - t0 != (MOD_LAT + 3) * 10) begin
      n_fail++;
      $display("FAIL b2b_mod_spacing: %0t between accepts, expected %0d", last_accept - t0, (MOD_LAT + 3) * 10);
    end
  endtask

  task automatic test_backpressure();
    bit bad;
    int cyc;
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'h100; req0_b = 32'h23;
    #1;
    n_tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: ready0=%b ready1=%b, expected 1 0", req0_ready, req1_ready);
    end
    @(posedge clk);
    exp_ptr = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = OP_OR; req1_a = 32'hA0; req1_b = 32'h05;
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h123 || rsp_id !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_rsp: valid=%b data=%h id=%b, expected 1 00000123 0", rsp_valid, rsp_data, rsp_id);
    end
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h123 || rsp_id !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_hold: response or readies changed under backpressure, expected data=00000123 id=0 readies 0");
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (req1_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: ready1=%b busy=%b, expected 1 0", req1_ready, busy);
    end
    @(posedge clk);
    exp_ptr = 1'b0;
    @(negedge clk);
    req1_valid = 1'b0;
    cyc = 1;
    while (rsp_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (rsp_valid !== 1'b1 || cyc != 2 || rsp_data !== 32'hA5 || rsp_id !== 1'b1 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_second: valid=%b cycle=%0d data=%h id=%b err=%b, expected 1 2 000000a5 1 0", rsp_valid, cyc, rsp_data, rsp_id, rsp_err);
    end
  endtask

  task automatic test_reset_mid_mod();
    bit stale;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = OP_MOD; req0_a = 32'd100; req0_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (9) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midmod_exec: busy=%b rsp_valid=%b at cycle 10, expected 1 0", busy, rsp_valid);
    end
    req1_valid = 1'b1;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, alu_clr, busy} !== 7'b0 ||
        rsp_data !== 0 || alu_a !== 0 || alu_b !== 0 || alu_sel !== 3'b000) begin
      n_fail++;
      $display("FAIL midmod_reset: r0=%b r1=%b valid=%b id=%b err=%b clr=%b busy=%b data=%h a=%h b=%h sel=%b, expected all 0",
               req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, alu_clr, busy, rsp_data, alu_a, alu_b, alu_sel);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    reset = 1'b1;
    exp_ptr = 1'b0;
    stale = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
    end
    n_tests++;
    if (stale) begin
      n_fail++;
      $display("FAIL midmod_stale: response or busy seen after reset release, expected none");
    end
    do_job(1, 0, OP_LT, 32'd3, 32'd9, OP_AND, 32'd0, 32'd0, "after_reset_lt");
  endtask

  task automatic test_random();
    bit          v0, v1;
    logic [2:0]  op0, op1;
    logic [31:0] a0, b0, a1, b1;
    for (int i = 0; i < 40; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      op0 = 3'($urandom_range(0, 7));
      op1 = 3'($urandom_range(0, 7));
      a0 = $urandom;
      a1 = $urandom;
      b0 = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 50)));
      b1 = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 50)));
      do_job(v0, v1, op0, a0, b0, op1, a1, b1, "random");
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_contention();
    test_add();
    test_contention_ptr1();
    test_mod();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_mod();
    test_random();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
